// File: rtl/acc_seq_pkg.sv
// Shared opcode, ALU-control and state definitions for the accumulator-machine sequencer.
package acc_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SLT  = 3'd2;
    localparam logic [2:0] OP_BZ   = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_MOVA = 3'd5;
    localparam logic [2:0] OP_MOVR = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_BR   = 2'b10;
    localparam logic [1:0] ALU_SLT  = 2'b11;

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } seqState_e;

    // SLT is not opcode[1:0] on the ALU side, so the mapping is spelled out
    function automatic logic [1:0] aluCtrlFor(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_NAND: return ALU_NAND;
            OP_SLT:  return ALU_SLT;
            OP_BZ:   return ALU_BR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/acc_sequencer_regfile.sv
// General register file: async read, sync write, synchronously cleared by rst_n.
module seq_regfile
    import acc_seq_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wrEn,
    input  logic [$clog2(NREGS)-1:0] wrIdx,
    input  logic [DW-1:0]            wrData,
    input  logic [$clog2(NREGS)-1:0] rdIdx,
    output logic [DW-1:0]            rdData
);

    logic [DW-1:0] regs_r [NREGS];

    // Register storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (wrEn) begin
            regs_r[wrIdx] <= wrData;
        end
    end

    assign rdData = regs_r[rdIdx];

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator machine; drives an external
// combinational ALU and owns PC, IR, accumulator, register file and the fetch handshake.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int PC_W  = 5,
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [1:0]      alu_ctrl,
    output logic [DW-1:0]   alu_acc,
    output logic [DW-1:0]   alu_b,
    input  logic [DW-1:0]   alu_result,
    output logic [DW-1:0]   acc_out,
    output logic [PC_W-1:0] pc_out,
    output logic            retire,
    output logic            halted
);

    localparam int IDX_W = $clog2(NREGS);

    seqState_e       state_r, stateNext_s;
    logic [PC_W-1:0] pc_r, pcNext_s;
    logic [DW-1:0]   acc_r, accNext_s, bNext_s, immExt_s, rdData_s;
    logic [7:0]      ir_r;
    logic [2:0]      opcode_s;
    logic [4:0]      imm_s;
    logic            wrEn_s;
    logic            imemReq_r, retire_r, halted_r;
    logic [1:0]      aluCtrl_r;
    logic [DW-1:0]   aluAcc_r, aluB_r;

    assign opcode_s = ir_r[7:5];
    assign imm_s    = ir_r[4:0];
    assign immExt_s = {{(DW-5){1'b0}}, imm_s};
    assign wrEn_s   = (state_r == ST_EXEC) && (opcode_s == OP_MOVA);

    seq_regfile #(.NREGS(NREGS), .DW(DW)) uRegfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrEn   (wrEn_s),
        .wrIdx  (ir_r[IDX_W-1:0]),
        .wrData (acc_r),
        .rdIdx  (ir_r[IDX_W-1:0]),
        .rdData (rdData_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_START;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; HALTED is left only through reset
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            ST_START:  stateNext_s = ST_FETCH;
            ST_FETCH: begin
                if (imem_valid) begin
                    stateNext_s = ST_DECODE;
                end else begin
                    stateNext_s = ST_FETCH;
                end
            end
            ST_DECODE: stateNext_s = ST_EXEC;
            ST_EXEC: begin
                if (opcode_s == OP_HALT) begin
                    stateNext_s = ST_HALTED;
                end else begin
                    stateNext_s = ST_FETCH;
                end
            end
            ST_HALTED: stateNext_s = ST_HALTED;
            default:   stateNext_s = ST_START;
        endcase
    end

    // Second operand selection made in DECODE
    always_comb begin
        bNext_s = {DW{1'b0}};
        case (opcode_s)
            OP_ADD, OP_NAND, OP_SLT, OP_MOVR: bNext_s = rdData_s;
            OP_BZ, OP_LDI:                    bNext_s = immExt_s;
            default:                          bNext_s = {DW{1'b0}};
        endcase
    end

    // EXEC effects; aluB_r holds the decoded operand while in EXEC
    always_comb begin
        accNext_s = acc_r;
        pcNext_s  = pc_r + PC_W'(1);
        case (opcode_s)
            OP_ADD, OP_NAND, OP_SLT: accNext_s = alu_result;
            OP_BZ: begin
                // Branch decision is local; alu_result is not trusted for BZ
                if (acc_r == {DW{1'b0}}) begin
                    pcNext_s = PC_W'(imm_s);
                end else begin
                    pcNext_s = pc_r + PC_W'(1);
                end
            end
            OP_LDI:  accNext_s = immExt_s;
            OP_MOVR: accNext_s = aluB_r;
            default: accNext_s = acc_r;
        endcase
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r      <= {PC_W{1'b0}};
            acc_r     <= {DW{1'b0}};
            ir_r      <= 8'd0;
            imemReq_r <= 1'b0;
            retire_r  <= 1'b0;
            halted_r  <= 1'b0;
            aluCtrl_r <= ALU_ADD;
            aluAcc_r  <= {DW{1'b0}};
            aluB_r    <= {DW{1'b0}};
        end else begin
            imemReq_r <= (stateNext_s == ST_FETCH);
            retire_r  <= (stateNext_s == ST_EXEC);
            halted_r  <= (stateNext_s == ST_HALTED);
            if ((state_r == ST_FETCH) && imem_valid) begin
                ir_r <= imem_data;
            end
            if (state_r == ST_DECODE) begin
                aluCtrl_r <= aluCtrlFor(opcode_s);
                aluAcc_r  <= acc_r;
                aluB_r    <= bNext_s;
            end else begin
                aluCtrl_r <= ALU_ADD;
                aluAcc_r  <= {DW{1'b0}};
                aluB_r    <= {DW{1'b0}};
            end
            if (state_r == ST_EXEC) begin
                acc_r <= accNext_s;
                pc_r  <= pcNext_s;
            end
        end
    end

    assign imem_req  = imemReq_r;
    assign imem_addr = pc_r;
    assign pc_out    = pc_r;
    assign acc_out   = acc_r;
    assign retire    = retire_r;
    assign halted    = halted_r;
    assign alu_ctrl  = aluCtrl_r;
    assign alu_acc   = aluAcc_r;
    assign alu_b     = aluB_r;

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench: hand-built program table, random programs against an ISA-level
// model, and a reset-during-fetch sequence.
module tb_acc_sequencer;

    logic       clk, rst_n;
    logic       imem_req, imem_valid, retire, halted;
    logic [4:0] imem_addr, pc_out;
    logic [7:0] imem_data, alu_acc, alu_b, alu_result, acc_out;
    logic [1:0] alu_ctrl;

    acc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .alu_ctrl(alu_ctrl),
        .alu_acc(alu_acc), .alu_b(alu_b), .alu_result(alu_result), .acc_out(acc_out),
        .pc_out(pc_out), .retire(retire), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU; the branch code yields junk that must never reach acc
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_acc + alu_b;
            2'b01:   alu_result = ~(alu_acc & alu_b);
            2'b10:   alu_result = 8'h5A;
            default: alu_result = (alu_acc < alu_b) ? 8'd1 : 8'd0;
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Instruction memory with configurable wait states
    logic [7:0] mem [32];
    bit memEnable = 1'b0;
    bit waitRandom = 1'b0;
    int waitCycles = 0;
    int stallCnt = 0;
    int curWait = 0;

    initial begin
        imem_valid = 1'b0;
        imem_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (memEnable) begin
                if (!imem_req) begin
                    imem_valid = 1'b0;
                    stallCnt   = 0;
                    curWait    = waitRandom ? int'($urandom_range(0, 3)) : waitCycles;
                end else if (stallCnt >= curWait) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                end else begin
                    imem_valid = 1'b0;
                    stallCnt++;
                end
            end
        end
    end

    // ISA-level reference model: per-instruction trace plus final state
    logic [4:0] mPcT [64];
    logic [1:0] mCtrlT [64];
    logic [7:0] mAccT [64];
    logic [7:0] mBT [64];
    bit         mBChk [64];
    int         mCount;
    logic [7:0] mAcc;
    logic [4:0] mPc;
    logic [7:0] mR [4];
    bit         mHalted;

    task automatic modelRun(input int maxSteps);
        logic [7:0] acc, ins;
        logic [4:0] pc, nextPc;
        logic [7:0] r [4];
        bit hlt;
        int n;
        acc = 8'd0; pc = 5'd0; hlt = 1'b0; n = 0;
        for (int i = 0; i < 4; i++) r[i] = 8'd0;
        while (!hlt && n < maxSteps) begin
            ins = mem[pc];
            mPcT[n] = pc; mAccT[n] = acc; mBChk[n] = 1'b1; mCtrlT[n] = 2'b00; mBT[n] = 8'd0;
            nextPc = pc + 5'd1;
            case (ins[7:5])
                3'd0: begin mBT[n] = r[ins[1:0]]; acc = acc + r[ins[1:0]]; end
                3'd1: begin mCtrlT[n] = 2'b01; mBT[n] = r[ins[1:0]]; acc = ~(acc & r[ins[1:0]]); end
                3'd2: begin mCtrlT[n] = 2'b11; mBT[n] = r[ins[1:0]]; acc = (acc < r[ins[1:0]]) ? 8'd1 : 8'd0; end
                3'd3: begin
                    mCtrlT[n] = 2'b10; mBT[n] = {3'd0, ins[4:0]};
                    if (acc == 8'd0) nextPc = ins[4:0];
                end
                3'd4: begin mBChk[n] = 1'b0; acc = {3'd0, ins[4:0]}; end
                3'd5: r[ins[1:0]] = acc;
                3'd6: begin mBT[n] = r[ins[1:0]]; acc = r[ins[1:0]]; end
                default: hlt = 1'b1;
            endcase
            pc = nextPc;
            n++;
        end
        mCount = n; mAcc = acc; mPc = pc; mHalted = hlt;
        for (int i = 0; i < 4; i++) mR[i] = r[i];
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run the program in mem and compare every retirement and the final state with the model
    task automatic runProg();
        int k, cyc, idleBad, addrBad, postBad;
        logic prevReq;
        logic [4:0] prevAddr;
        modelRun(40);
        memEnable = 1'b1;
        doReset();
        k = 0; cyc = 0; idleBad = 0; addrBad = 0; postBad = 0; prevReq = 1'b0; prevAddr = 5'd0;
        while (k < mCount && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                check("exec_pc", pc_out, mPcT[k]);
                check("exec_alu_ctrl", alu_ctrl, mCtrlT[k]);
                check("exec_alu_acc", alu_acc, mAccT[k]);
                if (mBChk[k]) check("exec_alu_b", alu_b, mBT[k]);
                k++;
            end else if (alu_ctrl != 2'b00 || alu_acc != 8'd0 || alu_b != 8'd0) begin
                idleBad++;
            end
            if (imem_req && prevReq && imem_addr != prevAddr) addrBad++;
            prevReq = imem_req;
            prevAddr = imem_addr;
        end
        check("retire_count", k, mCount);
        @(negedge clk);
        check("final_acc", acc_out, mAcc);
        check("final_pc", pc_out, mPc);
        for (int i = 0; i < 4; i++) check("final_reg", dut.uRegfile.regs_r[i], mR[i]);
        check("final_halted", halted, mHalted);
        if (mHalted) begin
            repeat (6) begin
                if (imem_req || retire || !halted) postBad++;
                @(negedge clk);
            end
            check("post_halt_quiet", postBad, 0);
        end
        check("alu_idle_outside_exec", idleBad, 0);
        check("fetch_addr_stable", addrBad, 0);
    endtask

    typedef struct {
        logic [31:0][7:0] code;
        int               waits;
        logic [7:0]       expAcc;
        logic [4:0]       expPc;
        logic [3:0][7:0]  expR;
        int               expRetire;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [31:0][7:0] mkCode(input logic [63:0] bytes8);
        logic [31:0][7:0] c;
        c = {32{8'hE0}};
        for (int i = 0; i < 8; i++) c[i] = bytes8[8*(7-i) +: 8];
        return c;
    endfunction

    initial begin
        int k, cyc, lateBad;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", imem_req, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_alu", {alu_ctrl, alu_acc, alu_b}, 0);
        check("rst_acc_pc", {acc_out, pc_out}, 0);

        // Programs with hand-computed results (bytes listed for addresses 0..7)
        tbl[0] = '{mkCode(64'h85A1_8301_E0E0_E0E0), 0, 8'h08, 5'd5, 32'h0000_0500, 5};
        tbl[1] = '{mkCode(64'h8FA2_8C22_E0E0_E0E0), 0, 8'hF3, 5'd5, 32'h000F_0000, 5};
        tbl[2] = '{mkCode(64'h8066_E0E0_E0E0_8166), 0, 8'h01, 5'd9, 32'h0000_0000, 5};
        tbl[3] = '{mkCode(64'h6287_61E0_E0E0_E0E0), 0, 8'h07, 5'd4, 32'h0000_0000, 5};
        tbl[4] = '{mkCode(64'h85A0_8340_E0E0_E0E0), 0, 8'h01, 5'd5, 32'h0000_0005, 5};
        tbl[5] = '{mkCode(64'h85A0_8540_E0E0_E0E0), 0, 8'h00, 5'd5, 32'h0000_0005, 5};
        tbl[6] = '{mkCode(64'h85A0_8640_E0E0_E0E0), 0, 8'h00, 5'd5, 32'h0000_0005, 5};
        tbl[7] = '{mkCode(64'h81A1_2001_E0E0_E0E0), 0, 8'h00, 5'd5, 32'h0000_0100, 5};
        tbl[8] = '{mkCode(64'h85A1_8301_E0E0_E0E0), 4, 8'h08, 5'd5, 32'h0000_0500, 5};

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 32; i++) mem[i] = tbl[v].code[i];
            waitRandom = 1'b0;
            waitCycles = tbl[v].waits;
            runProg();
            check("tbl_acc", acc_out, tbl[v].expAcc);
            check("tbl_pc", pc_out, tbl[v].expPc);
            check("tbl_retires", mCount, tbl[v].expRetire);
            for (int i = 0; i < 4; i++) check("tbl_reg", dut.uRegfile.regs_r[i], tbl[v].expR[i]);
        end

        // Fall-through from address 31 to 0: BZ 30; ...; 30: LDI 2; 31: LDI 3; 0: BZ 30 (not taken); 1: HALT
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
        mem[0] = 8'h7E; mem[30] = 8'h82; mem[31] = 8'h83;
        waitCycles = 0;
        runProg();
        check("wrap_acc", acc_out, 8'h03);
        check("wrap_pc", pc_out, 5'd2);

        // Random programs with random wait states
        waitRandom = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
            runProg();
        end
        waitRandom = 1'b0;

        // Reset during a stalled fetch, with a late imem_valid pulse while in START
        for (int i = 0; i < 32; i++) mem[i] = 8'hE0;
        mem[0] = 8'h85; mem[1] = 8'hA1; mem[2] = 8'h83;
        memEnable = 1'b1;
        waitCycles = 0;
        doReset();
        k = 0; cyc = 0;
        while (k < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (retire) k++;
        end
        memEnable = 1'b0;
        imem_valid = 1'b0;
        check("mid_retires", k, 3);
        repeat (3) @(negedge clk);
        check("mid_req", imem_req, 1);
        check("mid_addr", imem_addr, 5'd3);
        check("mid_acc", acc_out, 8'h03);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_acc_pc", {acc_out, pc_out}, 0);
        check("mid_rst_r1", dut.uRegfile.regs_r[1], 8'h00);
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_data = 8'h85;
        @(negedge clk);
        imem_valid = 1'b0;
        cyc = 0;
        while (!imem_req && cyc < 4) begin
            @(negedge clk);
            cyc++;
        end
        check("refetch_req", imem_req, 1);
        check("refetch_addr", imem_addr, 5'd0);
        lateBad = 0;
        repeat (4) begin
            @(negedge clk);
            if (retire || !imem_req || acc_out != 8'd0) lateBad++;
        end
        check("late_valid_ignored", lateBad, 0);
        memEnable = 1'b1;
        k = 0; cyc = 0;
        while (!halted && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (retire) k++;
        end
        check("rerun_halted", halted, 1);
        check("rerun_retires", k, 4);
        check("rerun_acc", acc_out, 8'h03);
        check("rerun_r1", dut.uRegfile.regs_r[1], 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
